svmdetect: RTL and testbench



---
 rtl/svmdet_pkg.sv | 15 +
 rtl/svmdet_fifo.sv | 65 ++++++
 rtl/svmdetect.sv | 143 ++++++++++++++
 tb/tb_svmdetect.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/svmdet_pkg.sv
// svmdet_pkg: shared constants, types and helpers for the svmdetect slice.
//   SCORE_W  - width of one SVM window score
//   score_t  - unsigned window score
//   idx_w()  - index width for a count of items (never less than 1 bit)
package svmdet_pkg;

    localparam int unsigned SCORE_W = 8;

    typedef logic [SCORE_W-1:0] score_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svmdet_fifo.sv
// svmdet_fifo: first-word-fall-through queue of detection records.
//   clk, reset_n : clock, synchronous active-low reset
//   push/push_data : write one record; ignored while full unless popping too
//   pop          : consume the head record (ignored when empty)
//   head         : current head record, all zeros while empty
//   full/empty   : occupancy flags
module svmdet_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type rec_t = logic [7:0]
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rec_t        mem_q [DEPTH];
    rec_t        mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push  = push && (!full || do_pop);
        head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/svmdetect.sv
// svmdetect: thresholds the svmrow score stream, applies 1-D horizontal
// non-maximum suppression and queues surviving (x, y, score) detections.
//   clk, reset_n      : clock, synchronous active-low reset
//   svmres_in, dvo_in : window score and its valid strobe
//   det_ready         : consumer accepts the head record
//   det_valid, det_x, det_y, det_score : head record of the detection queue
//   frame_done        : pulse in the decision cycle of the frame's last window
//   overflow          : sticky, a detection was dropped on a full queue
module svmdetect
    import svmdet_pkg::*;
#(
    parameter int unsigned WPI        = 40,
    parameter int unsigned NWROWS     = 30,
    parameter int unsigned THRESH     = 128,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned XW         = idx_w(WPI),
    parameter int unsigned YW         = idx_w(NWROWS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SCORE_W-1:0] svmres_in,
    input  logic               dvo_in,
    input  logic               det_ready,
    output logic               det_valid,
    output logic [XW-1:0]      det_x,
    output logic [YW-1:0]      det_y,
    output logic [SCORE_W-1:0] det_score,
    output logic               frame_done,
    output logic               overflow
);

    localparam logic [XW-1:0] X_LAST = XW'(WPI - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(NWROWS - 1);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        score_t        score;
    } det_rec_t;

    // x_q/y_q: position of the next arriving window.
    // s_*: window waiting for its right neighbour; l_q: its left neighbour.
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    score_t        s_score_q, s_score_d;
    logic [XW-1:0] s_x_q, s_x_d;
    logic [YW-1:0] s_y_q, s_y_d;
    logic          s_sv_q, s_sv_d;
    score_t        l_q, l_d;
    logic          overflow_q, overflow_d;

    logic          same_row;
    score_t        right;
    logic          decide;
    logic          detect;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    det_rec_t      push_rec;
    det_rec_t      head_rec;

    always_comb begin
        // An arrival at column 0 always starts a new row.
        same_row   = (x_q != '0);
        right      = (dvo_in && same_row) ? svmres_in : '0;
        decide     = s_sv_q && (dvo_in || (s_x_q == X_LAST));
        detect     = decide && (32'(s_score_q) >= THRESH) &&
                     (s_score_q > l_q) && (s_score_q >= right);
        pop        = !fifo_empty && det_ready;
        push_rec   = '{x: s_x_q, y: s_y_q, score: s_score_q};
        overflow_d = overflow_q || (detect && fifo_full && !pop);

        x_d       = x_q;
        y_d       = y_q;
        s_score_d = s_score_q;
        s_x_d     = s_x_q;
        s_y_d     = s_y_q;
        s_sv_d    = s_sv_q;
        l_d       = l_q;
        if (dvo_in) begin
            s_score_d = svmres_in;
            s_x_d     = x_q;
            s_y_d     = y_q;
            s_sv_d    = 1'b1;
            l_d       = same_row ? s_score_q : '0;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end else if (decide) begin
            s_sv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            s_score_q  <= '0;
            s_x_q      <= '0;
            s_y_q      <= '0;
            s_sv_q     <= 1'b0;
            l_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            s_score_q  <= s_score_d;
            s_x_q      <= s_x_d;
            s_y_q      <= s_y_d;
            s_sv_q     <= s_sv_d;
            l_q        <= l_d;
            overflow_q <= overflow_d;
        end
    end

    svmdet_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (det_rec_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (detect),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        det_valid  = !fifo_empty;
        det_x      = head_rec.x;
        det_y      = head_rec.y;
        det_score  = head_rec.score;
        overflow   = overflow_q;
        // Gated so the pulse reads 0 while reset is held.
        frame_done = reset_n && decide && (s_x_q == X_LAST) && (s_y_q == Y_LAST);
    end

endmodule

// File: tb/tb_svmdetect.sv
module tb_svmdetect;

    localparam int WPI    = 4;
    localparam int NWROWS = 2;
    localparam int THRESH = 128;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dvo_in;
    logic       det_ready;
    logic [7:0] svmres_in;

    logic       d8_valid, d2_valid, d8_fd, d2_fd, d8_ovf, d2_ovf;
    logic [1:0] d8_x, d2_x;
    logic [0:0] d8_y, d2_y;
    logic [7:0] d8_score, d2_score;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    svmdetect #(
        .WPI(WPI), .NWROWS(NWROWS), .THRESH(THRESH), .FIFO_DEPTH(8)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .svmres_in(svmres_in), .dvo_in(dvo_in),
        .det_ready(det_ready), .det_valid(d8_valid), .det_x(d8_x), .det_y(d8_y),
        .det_score(d8_score), .frame_done(d8_fd), .overflow(d8_ovf)
    );

    svmdetect #(
        .WPI(WPI), .NWROWS(NWROWS), .THRESH(THRESH), .FIFO_DEPTH(2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .svmres_in(svmres_in), .dvo_in(dvo_in),
        .det_ready(det_ready), .det_valid(d2_valid), .det_x(d2_x), .det_y(d2_y),
        .det_score(d2_score), .frame_done(d2_fd), .overflow(d2_ovf)
    );

    function automatic int pk(input int x, input int y, input int s);
        return x * 4096 + y * 256 + s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Window position is derived from the count of windows since reset;
    // a window is judged from its left/right neighbour scores.
    int  n_win = 0;
    bit  pend = 0;
    int  p_x = 0, p_y = 0, p_sc = 0, prev_sc = 0;
    int  mq8[$];
    int  mq2[$];
    bit  mo8 = 0, mo2 = 0;

    always @(negedge clk) begin
        int  in_x, right, left, efd;
        bit  dec, det;
        if (!reset_n) begin
            n_win = 0; pend = 0; p_x = 0; p_y = 0; p_sc = 0; prev_sc = 0;
            mq8.delete(); mq2.delete(); mo8 = 0; mo2 = 0;
        end else begin
            in_x  = n_win % WPI;
            dec   = pend && (dvo_in || p_x == WPI - 1);
            right = (dvo_in && in_x != 0) ? int'(svmres_in) : 0;
            left  = (p_x == 0) ? 0 : prev_sc;
            det   = dec && p_sc >= THRESH && p_sc > left && p_sc >= right;
            efd   = (dec && p_x == WPI - 1 && p_y == NWROWS - 1) ? 1 : 0;

            chk("m_valid8", d8_valid, mq8.size() != 0);
            if (mq8.size() != 0) chk("m_head8", pk(d8_x, d8_y, d8_score), mq8[0]);
            chk("m_ovf8", d8_ovf, mo8);
            chk("m_fd8", d8_fd, efd);
            chk("m_valid2", d2_valid, mq2.size() != 0);
            if (mq2.size() != 0) chk("m_head2", pk(d2_x, d2_y, d2_score), mq2[0]);
            chk("m_ovf2", d2_ovf, mo2);
            chk("m_fd2", d2_fd, efd);

            if (mq8.size() != 0 && det_ready) void'(mq8.pop_front());
            if (mq2.size() != 0 && det_ready) void'(mq2.pop_front());
            if (det) begin
                if (mq8.size() < 8) mq8.push_back(pk(p_x, p_y, p_sc)); else mo8 = 1;
                if (mq2.size() < 2) mq2.push_back(pk(p_x, p_y, p_sc)); else mo2 = 1;
            end
            if (dvo_in) begin
                prev_sc = p_sc;
                p_sc    = int'(svmres_in);
                p_x     = in_x;
                p_y     = (n_win / WPI) % NWROWS;
                pend    = 1;
                n_win   = (n_win + 1) % (WPI * NWROWS);
            end else if (dec) begin
                pend = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s);
        dvo_in    = 1'b1;
        svmres_in = 8'(s);
        step();
    endtask

    task automatic idle(input int n);
        dvo_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n = 1'b0; dvo_in = 1'b0; svmres_in = '0; det_ready = 1'b1;
        step(); step();
        chk("rst_valid", d8_valid, 0);
        chk("rst_x", d8_x, 0);
        chk("rst_y", d8_y, 0);
        chk("rst_score", d8_score, 0);
        chk("rst_fd", d8_fd, 0);
        chk("rst_ovf", d8_ovf, 0);
        chk("rst_valid2", d2_valid, 0);
        reset_n = 1'b1;

        // Row 0: single interior peak.
        send(10); send(200);
        chk("t1_not_yet", d8_valid, 0);
        send(150);
        chk("t1_valid", d8_valid, 1);
        chk("t1_rec", pk(d8_x, d8_y, d8_score), pk(1, 0, 200));
        send(90);

        // Row 1: peak at the row end, decided by flush; last window of frame.
        send(10); send(20); send(30); send(250);
        dvo_in = 1'b0;
        #1;
        chk("t2_fd", d8_fd, 1);
        chk("t2_pre", d8_valid, 0);
        step();
        chk("t2_valid", d8_valid, 1);
        chk("t2_rec", pk(d8_x, d8_y, d8_score), pk(3, 1, 250));
        idle(4);

        // Plateau: only the leftmost of two equal scores.
        send(50); send(180); send(180);
        chk("t3_rec", pk(d8_x, d8_y, d8_score), pk(1, 0, 180));
        send(60);
        send(0); send(0); send(0); send(0);
        idle(2);

        // Cross-row isolation.
        send(0); send(0); send(0); send(250);
        send(255);
        chk("t4_rec_a", pk(d8_x, d8_y, d8_score), pk(3, 0, 250));
        send(0);
        chk("t4_rec_b", pk(d8_x, d8_y, d8_score), pk(0, 1, 255));
        send(0); send(0);
        idle(3);

        // Full frame with consumer stalled: depth-2 queue overflows.
        det_ready = 1'b0;
        send(200); send(100); send(200); send(100);
        send(100); send(200); send(100); send(200);
        dvo_in = 1'b0;
        #1;
        chk("t5_fd", d8_fd, 1);
        step(); idle(2);
        chk("t5_ovf2", d2_ovf, 1);
        chk("t5_ovf8", d8_ovf, 0);
        chk("t5_head2", pk(d2_x, d2_y, d2_score), pk(0, 0, 200));
        chk("t5_head8", pk(d8_x, d8_y, d8_score), pk(0, 0, 200));
        det_ready = 1'b1;
        step();
        chk("t5_drain2", pk(d2_x, d2_y, d2_score), pk(2, 0, 200));
        chk("t5_drain8", pk(d8_x, d8_y, d8_score), pk(2, 0, 200));
        step();
        chk("t5_empty2", d2_valid, 0);
        chk("t5_drain8b", pk(d8_x, d8_y, d8_score), pk(1, 1, 200));
        idle(3);

        // Mid-row reset with three queued records.
        det_ready = 1'b0;
        send(200); send(100); send(200); send(100);
        send(100); send(200); send(50);
        dvo_in = 1'b0;
        step();
        chk("t6_queued", d8_valid, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_valid8", d8_valid, 0);
        chk("t6_valid2", d2_valid, 0);
        chk("t6_ovf2", d2_ovf, 0);
        det_ready = 1'b1;
        send(200); send(100);
        chk("t6_rec8", pk(d8_x, d8_y, d8_score), pk(0, 0, 200));
        chk("t6_rec2", pk(d2_x, d2_y, d2_score), pk(0, 0, 200));
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
